// File: rtl/edge_det_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : edge_det_pkg
//  Purpose  : Shared types and constants for the edge/event detector.
//             edge_mode_t is the 2-bit per-channel qualification mode:
//             00 off, 01 rise, 10 fall, 11 both.
//  Revision : 1.0  initial release
// ============================================================================
package edge_det_pkg;

    typedef logic [1:0] edge_mode_t;

    localparam edge_mode_t MODE_OFF  = 2'b00;
    localparam edge_mode_t MODE_RISE = 2'b01;
    localparam edge_mode_t MODE_FALL = 2'b10;
    localparam edge_mode_t MODE_BOTH = 2'b11;

    // True when a transition to new_level is a reportable edge under mode.
    function automatic logic edge_qualified(input edge_mode_t mode, input logic new_level);
        if (new_level) begin
            return (mode == MODE_RISE) || (mode == MODE_BOTH);
        end
        return (mode == MODE_FALL) || (mode == MODE_BOTH);
    endfunction

endpackage : edge_det_pkg
`default_nettype wire

// File: rtl/edge_det_chan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : edge_det_chan
//  Purpose  : One detector channel: synchroniser, glitch filter, edge
//             qualification, sticky flag and optional saturating counter.
//  Ports    : clk, areset     clock / async active-high reset
//             i_d             raw asynchronous input
//             i_mode          edge_mode_t qualification mode
//             i_clr           flag/counter clear pulse
//             o_level         filtered level
//             o_pulse         one-cycle qualified-edge pulse
//             o_flag          sticky qualified-edge flag
//             o_cnt           event count (0 unless EDGE_CNT_EN)
//  Config   : EDGE_CNT_EN enables the per-channel event counter.
//  Revision : 1.0  initial release
// ============================================================================
module edge_det_chan
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             i_d,
    input  edge_mode_t       i_mode,
    input  logic             i_clr,
    output logic             o_level,
    output logic             o_pulse,
    output logic             o_flag,
    output logic [CNT_W-1:0] o_cnt
);

    localparam int               c_FC_W   = $clog2(FILT_LEN) + 1;
    localparam logic [c_FC_W-1:0] c_FC_MAX = c_FC_W'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_FC_W-1:0]      r_fc;
    logic                   r_level;
    logic                   r_pulse;
    logic                   r_flag;

    logic w_s;
    logic w_accept;
    logic w_hit;

    assign w_s      = r_sync[SYNC_STAGES-1];
    // The new level is accepted on the edge where it has already been seen
    // FILT_LEN-1 times; pulse is registered alongside so both appear together.
    assign w_accept = (w_s != r_level) && (r_fc == c_FC_MAX);
    assign w_hit    = w_accept && edge_qualified(i_mode, w_s);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_sync  <= '0;
            r_fc    <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_flag  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            if (w_s == r_level) begin
                r_fc <= '0;
            end else if (w_accept) begin
                r_level <= w_s;
                r_fc    <= '0;
            end else begin
                r_fc <= r_fc + 1'b1;
            end
            r_pulse <= w_hit;
            // A new edge wins over a simultaneous clear.
            r_flag  <= w_hit | (r_flag & ~i_clr);
        end
    end

`ifdef EDGE_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= w_hit ? CNT_W'(1) : '0;
        end else if (w_hit && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
`else
    assign o_cnt = '0;
`endif

    assign o_level = r_level;
    assign o_pulse = r_pulse;
    assign o_flag  = r_flag;

endmodule : edge_det_chan
`default_nettype wire

// File: rtl/edge_event_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : edge_event_detector
//  Purpose  : N-channel edge/event detector for asynchronous control inputs.
//             Channels are independent; this level only slices ports and
//             registers the aggregate interrupt.
//  Ports    : clk, areset   clock / async active-high reset
//             D             raw inputs [N]
//             mode_i        per channel [2c+1:2c] mode
//             clr_i         per-channel flag/counter clear
//             level_o       filtered levels
//             pulse_o       qualified-edge pulses
//             flag_o        sticky flags
//             irq_o         registered OR of flag_o
//             cnt_o         per-channel counts (0 unless EDGE_CNT_EN)
//  Config   : EDGE_CNT_EN enables event counters.
//  Revision : 1.0  initial release
// ============================================================================
module edge_event_detector
    import edge_det_pkg::*;
#(
    parameter int N           = 1,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               areset,
    input  logic [N-1:0]       D,
    input  logic [2*N-1:0]     mode_i,
    input  logic [N-1:0]       clr_i,
    output logic [N-1:0]       level_o,
    output logic [N-1:0]       pulse_o,
    output logic [N-1:0]       flag_o,
    output logic               irq_o,
    output logic [N*CNT_W-1:0] cnt_o
);

    logic r_irq;

    for (genvar c = 0; c < N; c++) begin : g_chan
        edge_det_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk     (clk),
            .areset  (areset),
            .i_d     (D[c]),
            .i_mode  (edge_mode_t'(mode_i[2*c +: 2])),
            .i_clr   (clr_i[c]),
            .o_level (level_o[c]),
            .o_pulse (pulse_o[c]),
            .o_flag  (flag_o[c]),
            .o_cnt   (cnt_o[c*CNT_W +: CNT_W])
        );
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |flag_o;
        end
    end

    assign irq_o = r_irq;

endmodule : edge_event_detector
`default_nettype wire

// File: tb/tb_edge_event_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_edge_event_detector
//  Purpose  : Self-checking bench for edge_event_detector (N=4, SYNC=2,
//             FILT=4, CNT_W=2). A reference model pushes expected outputs
//             before every clock edge; they are popped and compared after it.
//  Config   : EDGE_CNT_EN selects counter expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_edge_event_detector;

    localparam int N     = 4;
    localparam int SYNC  = 2;
    localparam int FILT  = 4;
    localparam int CNT_W = 2;

    logic               clk = 1'b0;
    logic               areset;
    logic [N-1:0]       D;
    logic [2*N-1:0]     mode_i;
    logic [N-1:0]       clr_i;
    logic [N-1:0]       level_o;
    logic [N-1:0]       pulse_o;
    logic [N-1:0]       flag_o;
    logic               irq_o;
    logic [N*CNT_W-1:0] cnt_o;

    edge_event_detector #(
        .N           (N),
        .SYNC_STAGES (SYNC),
        .FILT_LEN    (FILT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk     (clk),
        .areset  (areset),
        .D       (D),
        .mode_i  (mode_i),
        .clr_i   (clr_i),
        .level_o (level_o),
        .pulse_o (pulse_o),
        .flag_o  (flag_o),
        .irq_o   (irq_o),
        .cnt_o   (cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]       level;
        logic [N-1:0]       pulse;
        logic [N-1:0]       flag;
        logic               irq;
        logic [N*CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    logic [SYNC-1:0] m_sync [N];
    logic [N-1:0]    m_level;
    logic [N-1:0]    m_pulse;
    logic [N-1:0]    m_flag;
    logic            m_irq;
    int              m_fc   [N];
    int              m_cnt  [N];

    int n_checks = 0;
    int n_pass   = 0;
    int pulses_seen [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_sync[c] = '0;
            m_fc[c]   = 0;
            m_cnt[c]  = 0;
        end
        m_level = '0;
        m_pulse = '0;
        m_flag  = '0;
        m_irq   = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic [N-1:0] old_flag;
        logic         s;
        logic [1:0]   md;
        exp_t         e;
        old_flag = m_flag;
        for (int c = 0; c < N; c++) begin
            s          = m_sync[c][SYNC-1];
            m_sync[c]  = {m_sync[c][SYNC-2:0], D[c]};
            m_pulse[c] = 1'b0;
            if (s != m_level[c]) begin
                if (m_fc[c] == FILT - 1) begin
                    m_level[c] = s;
                    m_fc[c]    = 0;
                    md         = mode_i[2*c +: 2];
                    m_pulse[c] = s ? (md == 2'b01 || md == 2'b11)
                                   : (md == 2'b10 || md == 2'b11);
                end else begin
                    m_fc[c] = m_fc[c] + 1;
                end
            end else begin
                m_fc[c] = 0;
            end
            m_flag[c] = m_pulse[c] | (m_flag[c] & ~clr_i[c]);
`ifdef EDGE_CNT_EN
            if (clr_i[c]) begin
                m_cnt[c] = m_pulse[c] ? 1 : 0;
            end else if (m_pulse[c] && m_cnt[c] < (1 << CNT_W) - 1) begin
                m_cnt[c] = m_cnt[c] + 1;
            end
`endif
        end
        m_irq   = |old_flag;
        e.level = m_level;
        e.pulse = m_pulse;
        e.flag  = m_flag;
        e.irq   = m_irq;
        e.cnt   = '0;
        for (int c = 0; c < N; c++) begin
            e.cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
        end
        sb_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            check("sb_level", 64'(level_o), 64'(e.level));
            check("sb_pulse", 64'(pulse_o), 64'(e.pulse));
            check("sb_flag",  64'(flag_o),  64'(e.flag));
            check("sb_irq",   64'(irq_o),   64'(e.irq));
            check("sb_cnt",   64'(cnt_o),   64'(e.cnt));
        end
        for (int c = 0; c < N; c++) begin
            if (pulse_o[c]) pulses_seen[c]++;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"}, 64'(level_o), 64'd0);
        check({tag, "_pulse"}, 64'(pulse_o), 64'd0);
        check({tag, "_flag"},  64'(flag_o),  64'd0);
        check({tag, "_irq"},   64'(irq_o),   64'd0);
        check({tag, "_cnt"},   64'(cnt_o),   64'd0);
    endtask

    logic [63:0] exp_sat;

    initial begin
`ifdef EDGE_CNT_EN
        exp_sat = 64'd3;
`else
        exp_sat = 64'd0;
`endif
        for (int c = 0; c < N; c++) pulses_seen[c] = 0;
        areset = 1'b1;
        D      = '0;
        clr_i  = '0;
        mode_i = 8'b01_01_01_01;
        model_reset();
        repeat (3) @(posedge clk);
        #3;
        check_all_zero("reset");
        areset = 1'b0;

        // Rising edge on channel 0: visible after edge 6, irq one edge later
        D[0] = 1'b1;
        ticks(5);
        check("t1_level_e5", 64'(level_o[0]), 64'd0);
        tick();
        check("t1_level_e6", 64'(level_o[0]), 64'd1);
        check("t1_pulse_e6", 64'(pulse_o[0]), 64'd1);
        check("t1_flag_e6",  64'(flag_o[0]),  64'd1);
        check("t1_irq_e6",   64'(irq_o),      64'd0);
        tick();
        check("t1_irq_e7",   64'(irq_o),      64'd1);
        check("t1_pulse_e7", 64'(pulse_o[0]), 64'd0);

        // 3-cycle glitch on channel 1 is filtered out
        D[1] = 1'b1;
        ticks(3);
        D[1] = 1'b0;
        ticks(10);
        check("t2_level", 64'(level_o[1]), 64'd0);
        check("t2_flag",  64'(flag_o[1]),  64'd0);
        check("t2_pulses", 64'(pulses_seen[1]), 64'd0);

        // Fall-only mode on channel 2, then both edges
        mode_i[5:4] = 2'b10;
        pulses_seen[2] = 0;
        D[2] = 1'b1;
        ticks(10);
        check("t3_fall_no_rise", 64'(pulses_seen[2]), 64'd0);
        check("t3_level_hi",     64'(level_o[2]),     64'd1);
        D[2] = 1'b0;
        ticks(10);
        check("t3_fall_one", 64'(pulses_seen[2]), 64'd1);
        mode_i[5:4] = 2'b11;
        pulses_seen[2] = 0;
        D[2] = 1'b1;
        ticks(10);
        D[2] = 1'b0;
        ticks(10);
        check("t3_both_two", 64'(pulses_seen[2]), 64'd2);

        // Clear behaviour on channel 0
        mode_i[1:0] = 2'b11;
        clr_i[0] = 1'b1;
        tick();
        clr_i[0] = 1'b0;
        check("t4_clr_alone", 64'(flag_o[0]), 64'd0);
        D[0] = 1'b0;
        ticks(5);
        clr_i[0] = 1'b1;
        tick();
        clr_i[0] = 1'b0;
        check("t4_clr_pulse_p", 64'(pulse_o[0]), 64'd1);
        check("t4_clr_pulse_f", 64'(flag_o[0]),  64'd1);
        clr_i = '1;
        tick();
        clr_i = '0;
        check("t4_flags_clr", 64'(flag_o), 64'd0);
        check("t4_irq_lag",   64'(irq_o),  64'd1);
        tick();
        check("t4_irq_drop",  64'(irq_o),  64'd0);

        // Five qualified edges on channel 3 saturate a 2-bit counter
        mode_i[7:6] = 2'b11;
        pulses_seen[3] = 0;
        for (int i = 0; i < 5; i++) begin
            D[3] = ~D[3];
            ticks(8);
        end
        check("t5_pulses", 64'(pulses_seen[3]), 64'd5);
        check("t5_cnt_sat", 64'(cnt_o[3*CNT_W +: CNT_W]), exp_sat);
        clr_i[3] = 1'b1;
        tick();
        clr_i[3] = 1'b0;
        check("t5_cnt_clr", 64'(cnt_o[3*CNT_W +: CNT_W]), 64'd0);

        // Async reset while channel 3 filter is mid-count
        D[3] = 1'b0;
        ticks(4);
        #2;
        areset = 1'b1;
        #1;
        check_all_zero("t6_async");
        model_reset();
        D = 4'b1000;
        #1;
        areset = 1'b0;
        pulses_seen[3] = 0;
        ticks(5);
        check("t6_pulse_e5", 64'(pulse_o[3]), 64'd0);
        tick();
        check("t6_pulse_e6", 64'(pulse_o[3]), 64'd1);
        check("t6_level_e6", 64'(level_o[3]), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_edge_event_detector
`default_nettype wire
